// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin one-hot arbiter and its mux checker.
package arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

  localparam int ARB_N_DEFAULT = 4;

  // Binary index of the set bit in a one-hot vector. Returns 0 for an all-zero vector.
  function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_onehot_arbiter_if.sv
// Request/ack/grant bundle between the requesters, the arbiter and the one-hot data mux.
interface rr_onehot_arbiter_if
  import arb_pkg::*;
#(
  parameter int N     = ARB_N_DEFAULT,
  parameter int IDX_W = $clog2(N)
);

  logic [N-1:0]     req;
  logic             ack;
  logic [N-1:0]     grant;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;

  // The arbiter consumes req/ack and owns the grant signals.
  modport master (
    input  req,
    input  ack,
    output grant,
    output grant_valid,
    output grant_idx
  );

  // Requesters and the consumer drive req/ack and watch the grant.
  modport slave (
    output req,
    output ack,
    input  grant,
    input  grant_valid,
    input  grant_idx
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit scanning from i_ptr upward with wrap.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_pick,
  output logic [IDX_W-1:0] o_pick_idx,
  output logic             o_any
);

  localparam int SUM_W = IDX_W + 1;

  logic [2*N-1:0]   w_dbl;
  logic [N-1:0]     w_rot;
  logic [IDX_W-1:0] w_off;
  logic             w_found;
  logic [SUM_W-1:0] w_sum;

  // Doubling the vector makes a plain right shift act as a rotate, so bit 0 of w_rot is req[ptr].
  assign w_dbl = {i_req, i_req};
  assign w_rot = N'(w_dbl >> i_ptr);

  // Lowest set bit of the rotated vector is the winner's distance from the pointer.
  always_comb begin
    w_off   = '0;
    w_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_found = 1'b1;
        w_off   = IDX_W'(i);
      end
    end
  end

  assign w_sum = SUM_W'(i_ptr) + SUM_W'(w_off);

  // Map the offset back to an absolute index modulo N and build the one-hot pick from it.
  always_comb begin
    o_pick_idx = (w_sum >= SUM_W'(N)) ? IDX_W'(w_sum - SUM_W'(N)) : IDX_W'(w_sum);
    o_pick     = w_found ? (N'(1) << o_pick_idx) : '0;
  end

  assign o_any = w_found;

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter whose registered one-hot grant drives a one-hot data mux select directly.
module rr_onehot_arbiter
  import arb_pkg::*;
#(
  parameter int N     = ARB_N_DEFAULT,
  parameter int IDX_W = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  rr_onehot_arbiter_if.master bus
);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_ptr_nxt;
  logic [N-1:0]     r_grant;
  logic [N-1:0]     w_grant_nxt;
  logic [IDX_W-1:0] r_grant_idx;
  logic [IDX_W-1:0] w_grant_idx_nxt;
  logic             r_grant_valid;
  logic             w_grant_valid_nxt;

  logic [IDX_W-1:0] w_adv_ptr;
  logic [IDX_W-1:0] w_pick_ptr;
  logic [N-1:0]     w_pick;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_any;

  // An acked transfer hands priority to the requester just after the winner, so the
  // same-edge re-arbitration already scans from the advanced pointer.
  assign w_adv_ptr  = (r_grant_idx == IDX_W'(N - 1)) ? '0 : r_grant_idx + IDX_W'(1);
  assign w_pick_ptr = (r_state == ARB_GRANT && bus.ack) ? w_adv_ptr : r_ptr;

  rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req      (bus.req),
    .i_ptr      (w_pick_ptr),
    .o_pick     (w_pick),
    .o_pick_idx (w_pick_idx),
    .o_any      (w_any)
  );

  // Next state: grant from idle, hold until ack or withdrawal, chain grants without a bubble.
  always_comb begin
    w_state_nxt       = r_state;
    w_ptr_nxt         = r_ptr;
    w_grant_nxt       = r_grant;
    w_grant_idx_nxt   = r_grant_idx;
    w_grant_valid_nxt = r_grant_valid;
    case (r_state)
      ARB_IDLE: begin
        if (w_any) begin
          w_state_nxt       = ARB_GRANT;
          w_grant_nxt       = w_pick;
          w_grant_idx_nxt   = w_pick_idx;
          w_grant_valid_nxt = 1'b1;
        end
      end
      ARB_GRANT: begin
        if (bus.ack) begin
          w_ptr_nxt = w_adv_ptr;
          if (w_any) begin
            w_grant_nxt       = w_pick;
            w_grant_idx_nxt   = w_pick_idx;
            w_grant_valid_nxt = 1'b1;
          end else begin
            w_state_nxt       = ARB_IDLE;
            w_grant_nxt       = '0;
            w_grant_idx_nxt   = '0;
            w_grant_valid_nxt = 1'b0;
          end
        end else if (!bus.req[r_grant_idx]) begin
          w_state_nxt       = ARB_IDLE;
          w_grant_nxt       = '0;
          w_grant_idx_nxt   = '0;
          w_grant_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt       = ARB_IDLE;
        w_grant_nxt       = '0;
        w_grant_idx_nxt   = '0;
        w_grant_valid_nxt = 1'b0;
      end
    endcase
  end

  // State, pointer and grant registers; reset clears the mux select without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ARB_IDLE;
      r_ptr         <= '0;
      r_grant       <= '0;
      r_grant_idx   <= '0;
      r_grant_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ptr         <= w_ptr_nxt;
      r_grant       <= w_grant_nxt;
      r_grant_idx   <= w_grant_idx_nxt;
      r_grant_valid <= w_grant_valid_nxt;
    end
  end

  assign bus.grant       = r_grant;
  assign bus.grant_idx   = r_grant_idx;
  assign bus.grant_valid = r_grant_valid;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Self-checking bench for rr_onehot_arbiter: directed vector table plus randomized run against a reference model.
module tb_rr_onehot_arbiter;
  import arb_pkg::*;

  localparam int N = 4;

  typedef struct {
    logic       rstN;
    logic [3:0] req;
    logic       ack;
    logic [3:0] expGrant;
    logic       expValid;
    logic [1:0] expIdx;
    string      name;
  } vecT;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  int   mPtr;
  bit   mValid;
  int   mIdx;

  vecT  vecs[$];

  rr_onehot_arbiter_if #(.N(N)) bus ();

  rr_onehot_arbiter #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // First requester at or after p in circular order, -1 if nobody is requesting.
  function automatic int winner(input logic [3:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p + k) % N;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  // Reference model: advance one clock edge given the inputs seen before that edge.
  task automatic modelStep(input logic rstN, input logic [3:0] req, input logic ack);
    int w;
    if (!rstN) begin
      mPtr = 0; mValid = 0; mIdx = 0;
    end else if (!mValid) begin
      w = winner(req, mPtr);
      if (w >= 0) begin mValid = 1; mIdx = w; end
    end else if (ack) begin
      mPtr = (mIdx + 1) % N;
      w = winner(req, mPtr);
      if (w >= 0) mIdx = w;
      else begin mValid = 0; mIdx = 0; end
    end else if (!req[mIdx]) begin
      mValid = 0; mIdx = 0;
    end
  endtask

  function automatic vecT mkVec(input logic rstN, input logic [3:0] req, input logic ack,
                                input logic [3:0] g, input logic v, input logic [1:0] i, input string name);
    vecT t;
    t.rstN = rstN; t.req = req; t.ack = ack;
    t.expGrant = g; t.expValid = v; t.expIdx = i; t.name = name;
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [3:0] expGrant, input logic expValid, input logic [1:0] expIdx);
    checks++;
    if (bus.grant !== expGrant || bus.grant_valid !== expValid || bus.grant_idx !== expIdx) begin
      errors++;
      $display("[TB] FAIL %s: got grant=%b valid=%b idx=%0d, expected grant=%b valid=%b idx=%0d",
               name, bus.grant, bus.grant_valid, bus.grant_idx, expGrant, expValid, expIdx);
    end
  endtask

  // One-hot invariant on the grant, evaluated after every clock edge.
  task automatic checkInvariant();
    logic [3:0] g;
    bit ok;
    g = bus.grant;
    ok = ((g & (g - 4'd1)) == 4'd0) && (bus.grant_valid === (|g)) &&
         (bus.grant_valid ? (bus.grant[bus.grant_idx] === 1'b1 && onehot_to_idx(32'(g)) == 32'(bus.grant_idx))
                          : (bus.grant_idx === 2'd0));
    checks++;
    assert (ok) else begin
      errors++;
      $display("[TB] FAIL invariant at %0t: grant=%b valid=%b idx=%0d", $time, bus.grant, bus.grant_valid, bus.grant_idx);
    end
  endtask

  task automatic applyStimulus(input logic rstN, input logic [3:0] req, input logic ack);
    rst_n   = rstN;
    bus.req = req;
    bus.ack = ack;
    @(posedge clk);
    #1;
    checkInvariant();
  endtask

  initial begin
    logic       rRst;
    logic [3:0] rReq;
    logic       rAck;
    checks  = 0;
    errors  = 0;
    mPtr = 0; mValid = 0; mIdx = 0;
    rst_n   = 1'b1;
    bus.req = 4'b0000;
    bus.ack = 1'b0;
    #2 rst_n = 1'b0;

    // Reset held with every requester active, then an asynchronous drop mid-grant.
    $display("[TB] reset behaviour");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 4'b1111, 1'b0);
      checkOutput("t1 reset hold", 4'b0000, 1'b0, 2'd0);
    end
    applyStimulus(1'b1, 4'b1111, 1'b0);
    checkOutput("t1 grant after release", 4'b0001, 1'b1, 2'd0);
    #3 rst_n = 1'b0;
    #1 checkOutput("t1 async drop", 4'b0000, 1'b0, 2'd0);
    applyStimulus(1'b0, 4'b1111, 1'b0);
    checkOutput("t1 reset after drop", 4'b0000, 1'b0, 2'd0);

    // Directed vectors; each row is applied before an edge and checked after it.
    vecs.push_back(mkVec(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, "reset row"));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mkVec(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, "t6 idle ack"));
    vecs.push_back(mkVec(1'b1, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, "t6 grant 1"));
    vecs.push_back(mkVec(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, "t6 withdraw"));
    vecs.push_back(mkVec(1'b1, 4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0, "t6 ptr still 0"));
    vecs.push_back(mkVec(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, "t6 ack to idle"));
    vecs.push_back(mkVec(1'b1, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, "t2 first grant"));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mkVec(1'b1, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, "t2 hold"));
    vecs.push_back(mkVec(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, "t2 ack release"));
    vecs.push_back(mkVec(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, "reset row"));
    vecs.push_back(mkVec(1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, "t3 rr 0"));
    vecs.push_back(mkVec(1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, "t3 rr 1"));
    vecs.push_back(mkVec(1'b1, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, "t3 rr 2"));
    vecs.push_back(mkVec(1'b1, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, "t3 rr 3"));
    vecs.push_back(mkVec(1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, "t3 rr wrap"));
    vecs.push_back(mkVec(1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, "t4 grant 1"));
    vecs.push_back(mkVec(1'b1, 4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0, "t4 scan wraps"));
    vecs.push_back(mkVec(1'b1, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, "t5 grant 1"));
    vecs.push_back(mkVec(1'b1, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, "t5 grant 2"));
    vecs.push_back(mkVec(1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0, 2'd0, "t5 withdraw"));
    vecs.push_back(mkVec(1'b1, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, "t5 regrant"));
    vecs.push_back(mkVec(1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, "sole requester regrant"));
    vecs.push_back(mkVec(1'b1, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, "ack with withdraw"));
    vecs.push_back(mkVec(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, "ack to idle"));
    vecs.push_back(mkVec(1'b1, 4'b1001, 1'b0, 4'b1000, 1'b1, 2'd3, "ptr at top"));

    $display("[TB] directed vectors: %0d rows", vecs.size());
    foreach (vecs[k]) begin
      applyStimulus(vecs[k].rstN, vecs[k].req, vecs[k].ack);
      checkOutput(vecs[k].name, vecs[k].expGrant, vecs[k].expValid, vecs[k].expIdx);
    end

    // Randomized traffic with occasional resets, compared against the reference model.
    $display("[TB] random traffic");
    applyStimulus(1'b0, 4'b0000, 1'b0);
    modelStep(1'b0, 4'b0000, 1'b0);
    for (int k = 0; k < 800; k++) begin
      rRst = ($urandom_range(0, 63) != 0);
      rReq = ($urandom_range(0, 3) == 0) ? 4'b1111 : 4'($urandom_range(0, 15));
      rAck = ($urandom_range(0, 2) != 0);
      modelStep(rRst, rReq, rAck);
      applyStimulus(rRst, rReq, rAck);
      checkOutput("random", mValid ? 4'(1 << mIdx) : 4'b0000, mValid, mValid ? 2'(mIdx) : 2'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
